// File: rtl/rr_prio_arb_pkg.sv
// Shared types for the round-robin priority arbiter: index width, hold counter
// width and a saturating increment helper.
package rr_prio_arb_pkg;

    localparam int unsigned IDX_W = 8;
    localparam int unsigned CNT_W = 16;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_prio_arb_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_prio_arb_if
    import rr_prio_arb_pkg::*;
#(
    parameter int unsigned WIDTH_LOG = 4
);
    localparam int unsigned WIDTH = 1 << WIDTH_LOG;

    logic [WIDTH-1:0] req;
    logic             gnt_release;
    logic             gnt_valid;
    idx_t             gnt_idx;
    logic [WIDTH-1:0] gnt_onehot;
    logic             timeout;

    modport master (
        output req, gnt_release,
        input  gnt_valid, gnt_idx, gnt_onehot, timeout
    );

    modport slave (
        input  req, gnt_release,
        output gnt_valid, gnt_idx, gnt_onehot, timeout
    );

endinterface

// File: rtl/rr_prio_arb_prio_enc.sv
// Priority encoder: reports the index of the highest set bit of vec.
module rr_prio_arb_prio_enc
    import rr_prio_arb_pkg::*;
#(
    parameter int unsigned WIDTH_LOG = 4
) (
    input  logic [(1 << WIDTH_LOG)-1:0] vec,
    output idx_t                        msb,
    output logic                        valid
);
    localparam int unsigned WIDTH = 1 << WIDTH_LOG;

    // Ascending scan so the last hit, i.e. the highest index, wins.
    always_comb begin
        msb   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                msb   = idx_t'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_prio_arb.sv
// Sticky-grant round-robin arbiter: a grant holds until release or hold timeout,
// and the next search starts just below the previous winner.
module rr_prio_arb
    import rr_prio_arb_pkg::*;
#(
    parameter int unsigned WIDTH_LOG = 4,
    parameter int unsigned HOLD_MAX  = 16
) (
    input logic         clk,
    input logic         rst_n,
    rr_prio_arb_if.slave bus
);
    localparam int unsigned WIDTH = 1 << WIDTH_LOG;

    localparam logic IDLE  = 1'b0;
    localparam logic GRANT = 1'b1;

    logic state_q, state_d;
    logic valid_q, valid_d;
    idx_t idx_q, idx_d;
    idx_t last_q, last_d;
    cnt_t cnt_q, cnt_d;
    logic to_q, to_d;

    logic [WIDTH-1:0] mask, masked;
    idx_t             enc_m, enc_r, winner;
    logic             m_any, r_any;
    logic             hold_hit;

    // Only indices strictly below the previous winner take precedence.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            mask[i] = (idx_t'(i) < last_q);
        end
    end

    assign masked = bus.req & mask;

    rr_prio_arb_prio_enc #(
        .WIDTH_LOG(WIDTH_LOG)
    ) u_enc_masked (
        .vec  (masked),
        .msb  (enc_m),
        .valid(m_any)
    );

    rr_prio_arb_prio_enc #(
        .WIDTH_LOG(WIDTH_LOG)
    ) u_enc_raw (
        .vec  (bus.req),
        .msb  (enc_r),
        .valid(r_any)
    );

    assign winner   = m_any ? enc_m : enc_r;
    assign hold_hit = (HOLD_MAX != 0) && (32'(cnt_q) == HOLD_MAX - 32'd1);

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (r_any) begin
                    state_d = GRANT;
                    valid_d = 1'b1;
                    idx_d   = winner;
                    last_d  = winner;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                cnt_d = sat_inc(cnt_q);
                if (bus.gnt_release) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else if (hold_hit) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    to_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        bus.gnt_onehot = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bus.gnt_onehot[i] = valid_q && (idx_q == idx_t'(i));
        end
    end

    assign bus.gnt_valid = valid_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.timeout   = to_q;

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        bus.gnt_valid |-> (bus.gnt_onehot == (WIDTH'(1) << bus.gnt_idx)));
    a_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
        32'(bus.gnt_idx) < WIDTH);
    a_timeout_idle: assert property (@(posedge clk) disable iff (!rst_n)
        bus.timeout |-> !bus.gnt_valid);

endmodule

// File: tb/tb_rr_prio_arb.sv
// Bench for rr_prio_arb: two instances (HOLD_MAX=4 and HOLD_MAX=0) against a
// cycle-level reference model, with directed and random stimulus.
module tb_rr_prio_arb;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rr_prio_arb_if #(.WIDTH_LOG(2)) bus_a ();
    rr_prio_arb_if #(.WIDTH_LOG(2)) bus_b ();

    rr_prio_arb #(.WIDTH_LOG(2), .HOLD_MAX(4)) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_a)
    );

    rr_prio_arb #(.WIDTH_LOG(2), .HOLD_MAX(0)) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    int  hold_lim[2] = '{4, 0};
    bit  m_gnt[2];
    int  m_owner[2];
    int  m_ptr[2];
    int  m_held[2];
    bit  m_to[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Next requester searching downward from ptr-1, wrapping to the top.
    function automatic int pick(input int ptr, input logic [3:0] r);
        for (int k = 1; k <= W; k++) begin
            int i;
            i = (ptr - k + W) % W;
            if (r[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_gnt[d] = 0; m_owner[d] = 0; m_ptr[d] = 0; m_held[d] = 0; m_to[d] = 0;
        end
    endtask

    task automatic model_step(input int d, input logic [3:0] r, input logic rel);
        if (!m_gnt[d]) begin
            m_to[d] = 0;
            if (r != 0) begin
                m_owner[d] = pick(m_ptr[d], r);
                m_ptr[d]   = m_owner[d];
                m_gnt[d]   = 1;
                m_held[d]  = 1;
            end
        end else if (rel) begin
            m_gnt[d] = 0;
            m_to[d]  = 0;
        end else if (hold_lim[d] != 0 && m_held[d] == hold_lim[d]) begin
            m_gnt[d] = 0;
            m_to[d]  = 1;
        end else begin
            m_held[d]++;
            m_to[d] = 0;
        end
    endtask

    task automatic compare_dut(input int d);
        logic       v, t;
        logic [7:0] idx;
        logic [3:0] oh;
        v   = d ? bus_b.gnt_valid  : bus_a.gnt_valid;
        t   = d ? bus_b.timeout    : bus_a.timeout;
        idx = d ? bus_b.gnt_idx    : bus_a.gnt_idx;
        oh  = d ? bus_b.gnt_onehot : bus_a.gnt_onehot;
        check($sformatf("d%0d valid", d), 32'(v), 32'(m_gnt[d]));
        check($sformatf("d%0d idx", d), 32'(idx), 32'(m_owner[d]));
        check($sformatf("d%0d onehot", d), 32'(oh), m_gnt[d] ? (32'd1 << m_owner[d]) : 32'd0);
        check($sformatf("d%0d timeout", d), 32'(t), 32'(m_to[d]));
    endtask

    // Called at a falling edge: drive, let one rising edge pass, then compare.
    task automatic tick(input logic [3:0] r, input logic ra, input logic rb);
        bus_a.req = r;  bus_a.gnt_release = ra;
        bus_b.req = r;  bus_b.gnt_release = rb;
        @(posedge clk);
        model_step(0, r, ra);
        model_step(1, r, rb);
        @(negedge clk);
        compare_dut(0);
        compare_dut(1);
    endtask

    int seq[5] = '{3, 2, 1, 0, 3};
    int b_drop;

    initial begin
        rst_n = 1'b0;
        bus_a.req = '0; bus_a.gnt_release = 1'b0;
        bus_b.req = '0; bus_b.gnt_release = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_dut(0);
        compare_dut(1);
        rst_n = 1'b1;

        // First grant goes to the highest requester, then rotate downward.
        tick(4'hF, 1'b0, 1'b0);
        check("first idx", 32'(bus_a.gnt_idx), 32'd3);
        check("first onehot", 32'(bus_a.gnt_onehot), 32'h8);
        for (int j = 1; j < 5; j++) begin
            tick(4'hF, 1'b1, 1'b0);
            check("gap valid", 32'(bus_a.gnt_valid), 32'd0);
            tick(4'hF, 1'b0, 1'b0);
            check("rr idx", 32'(bus_a.gnt_idx), 32'(seq[j]));
        end

        tick(4'hF, 1'b1, 1'b0);
        tick(4'hF, 1'b0, 1'b0);
        check("last2 idx", 32'(bus_a.gnt_idx), 32'd2);
        tick(4'h5, 1'b1, 1'b0);
        tick(4'h5, 1'b0, 1'b0);
        check("masked idx", 32'(bus_a.gnt_idx), 32'd0);
        tick(4'h5, 1'b1, 1'b0);
        tick(4'h5, 1'b0, 1'b0);
        check("wrap idx", 32'(bus_a.gnt_idx), 32'd2);

        // Hold timeout with requests dropped.
        tick(4'h2, 1'b1, 1'b0);
        tick(4'h2, 1'b0, 1'b0);
        check("to grant idx", 32'(bus_a.gnt_idx), 32'd1);
        for (int j = 0; j < 3; j++) begin
            tick(4'h0, 1'b0, 1'b0);
            check("held valid", 32'(bus_a.gnt_valid), 32'd1);
        end
        tick(4'h0, 1'b0, 1'b0);
        check("to valid", 32'(bus_a.gnt_valid), 32'd0);
        check("to pulse", 32'(bus_a.timeout), 32'd1);
        tick(4'h0, 1'b0, 1'b0);
        check("to one cycle", 32'(bus_a.timeout), 32'd0);

        // Release on the last allowed cycle beats the timeout.
        tick(4'h2, 1'b0, 1'b0);
        check("rel grant idx", 32'(bus_a.gnt_idx), 32'd1);
        repeat (3) tick(4'h0, 1'b0, 1'b0);
        tick(4'h0, 1'b1, 1'b0);
        check("rel valid", 32'(bus_a.gnt_valid), 32'd0);
        check("rel no to", 32'(bus_a.timeout), 32'd0);

        // dut_b (no timeout) has held its grant throughout; keep holding.
        b_drop = 0;
        for (int j = 0; j < 100; j++) begin
            tick(4'($urandom), 1'($urandom), 1'b0);
            if (!bus_b.gnt_valid || bus_b.timeout) b_drop++;
        end
        check("hold0 drops", 32'(b_drop), 32'd0);

        for (int j = 0; j < 400; j++) begin
            tick(4'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset between edges while both hold grants.
        for (int k = 0; k < 10; k++) begin
            if (!(bus_a.gnt_valid && bus_b.gnt_valid)) tick(4'hF, 1'b0, 1'b0);
        end
        check("pre-rst valid", 32'(bus_a.gnt_valid && bus_b.gnt_valid), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst valid a", 32'(bus_a.gnt_valid), 32'd0);
        check("rst onehot a", 32'(bus_a.gnt_onehot), 32'd0);
        check("rst valid b", 32'(bus_b.gnt_valid), 32'd0);
        model_reset();
        @(negedge clk);
        compare_dut(0);
        compare_dut(1);
        rst_n = 1'b1;
        tick(4'h3, 1'b0, 1'b0);
        check("post-rst idx a", 32'(bus_a.gnt_idx), 32'd1);
        check("post-rst idx b", 32'(bus_b.gnt_idx), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
